// File: rtl/dual_issue_regfile.sv
// Dual-issue architectural GPR file: two WB write ports (B wins on collision), four ID read ports, registered debug read.
// Optional same-cycle WB->ID forwarding is enabled by defining REGFILE_BYPASS_EN.
module dual_issue_regfile #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 5,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  WB_rf_we_a,
  input  logic [ADDR_WIDTH-1:0] WB_rf_waddr_a,
  input  logic [DATA_WIDTH-1:0] WB_rf_wdata_a,
  input  logic                  WB_rf_we_b,
  input  logic [ADDR_WIDTH-1:0] WB_rf_waddr_b,
  input  logic [DATA_WIDTH-1:0] WB_rf_wdata_b,
  input  logic [ADDR_WIDTH-1:0] ID_raddr_a1,
  input  logic [ADDR_WIDTH-1:0] ID_raddr_a2,
  input  logic [ADDR_WIDTH-1:0] ID_raddr_b1,
  input  logic [ADDR_WIDTH-1:0] ID_raddr_b2,
  output logic [DATA_WIDTH-1:0] ID_rdata_a1,
  output logic [DATA_WIDTH-1:0] ID_rdata_a2,
  output logic [DATA_WIDTH-1:0] ID_rdata_b1,
  output logic [DATA_WIDTH-1:0] ID_rdata_b2,
  input  logic                  dbg_re,
  input  logic [ADDR_WIDTH-1:0] dbg_raddr,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  // Entry 0 is never written, so it stays at zero and r0 reads need no special case.
  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [DATA_WIDTH-1:0] regs_d [NREG];

  logic                  dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q,  dbg_rdata_d;

  logic we_a_ok, we_b_ok;

  // Writes are suppressed while reset is held so neither storage nor forwarding sees them.
  assign we_a_ok = WB_rf_we_a & rstn & (WB_rf_waddr_a != '0);
  assign we_b_ok = WB_rf_we_b & rstn & (WB_rf_waddr_b != '0);

  // regs_d is the post-bypass view of the file: the value each register holds after the next edge.
  always_comb begin
    // NOTE: default every element first so no path leaves regs_d unassigned, which would infer latches.
    regs_d = regs_q;
    for (int i = 1; i < NREG; i++) begin
      // NOTE: blocking assignments in order: slot B is applied last, so the younger write wins a collision.
      if (we_a_ok && (WB_rf_waddr_a == ADDR_WIDTH'(i))) regs_d[i] = WB_rf_wdata_a;
      if (we_b_ok && (WB_rf_waddr_b == ADDR_WIDTH'(i))) regs_d[i] = WB_rf_wdata_b;
    end
  end

  always_comb begin
    dbg_rvalid_d = dbg_re;
    dbg_rdata_d  = dbg_rdata_q;
    if (dbg_re) dbg_rdata_d = regs_d[dbg_raddr];
  end

  // NOTE: the GPRs are flops, not a RAM macro, so they take the async reset like any other state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regs_q[0] <= '0;
      for (int i = 1; i < NREG; i++) regs_q[i] <= RESET_VALUE;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
    end else begin
      regs_q       <= regs_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarded view: a WB write is visible to ID in the cycle it is presented.
  assign ID_rdata_a1 = regs_d[ID_raddr_a1];
  assign ID_rdata_a2 = regs_d[ID_raddr_a2];
  assign ID_rdata_b1 = regs_d[ID_raddr_b1];
  assign ID_rdata_b2 = regs_d[ID_raddr_b2];
`else
  // Stored view only: the hazard unit covers the cycle between write and visibility.
  assign ID_rdata_a1 = regs_q[ID_raddr_a1];
  assign ID_rdata_a2 = regs_q[ID_raddr_a2];
  assign ID_rdata_b1 = regs_q[ID_raddr_b1];
  assign ID_rdata_b2 = regs_q[ID_raddr_b2];
`endif

  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;

  a_r0_zero: assert property (@(posedge clk) regs_q[0] == '0);

endmodule

// File: tb/tb_dual_issue_regfile.sv
// Self-checking bench for dual_issue_regfile: vector table for write/read/debug behaviour,
// a debug-read scoreboard queue, and hand-written reset sequences.
module tb_dual_issue_regfile;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;
  localparam int NV   = 11;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          we_a, we_b;
  logic [AW-1:0] waddr_a, waddr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic [AW-1:0] raddr_a1, raddr_a2, raddr_b1, raddr_b2;
  logic [DW-1:0] rdata_a1, rdata_a2, rdata_b1, rdata_b2;
  logic          dbg_re;
  logic [AW-1:0] dbg_raddr;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  dual_issue_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_VALUE('0)) dut (
    .clk(clk), .rstn(rstn),
    .WB_rf_we_a(we_a), .WB_rf_waddr_a(waddr_a), .WB_rf_wdata_a(wdata_a),
    .WB_rf_we_b(we_b), .WB_rf_waddr_b(waddr_b), .WB_rf_wdata_b(wdata_b),
    .ID_raddr_a1(raddr_a1), .ID_raddr_a2(raddr_a2), .ID_raddr_b1(raddr_b1), .ID_raddr_b2(raddr_b2),
    .ID_rdata_a1(rdata_a1), .ID_rdata_a2(rdata_a2), .ID_rdata_b1(rdata_b1), .ID_rdata_b2(rdata_b2),
    .dbg_re(dbg_re), .dbg_raddr(dbg_raddr), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we_a;
    logic [AW-1:0] waddr_a;
    logic [DW-1:0] wdata_a;
    logic          we_b;
    logic [AW-1:0] waddr_b;
    logic [DW-1:0] wdata_b;
    logic [AW-1:0] chk_addr;
    logic [DW-1:0] exp_after;
  } vec_t;

  vec_t          vecs [NV];
  logic [DW-1:0] model [NREG];
  logic [DW-1:0] dbg_sb [$];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_raddr(input logic [AW-1:0] a);
    raddr_a1 = a; raddr_a2 = a; raddr_b1 = a; raddr_b2 = a;
  endtask

  task automatic check_all(input string name, input logic [DW-1:0] exp);
    check({name, " a1"}, rdata_a1, exp);
    check({name, " a2"}, rdata_a2, exp);
    check({name, " b1"}, rdata_b1, exp);
    check({name, " b2"}, rdata_b2, exp);
  endtask

  task automatic model_write(input vec_t v);
    if (v.we_a && v.waddr_a != '0) model[v.waddr_a] = v.wdata_a;
    if (v.we_b && v.waddr_b != '0) model[v.waddr_b] = v.wdata_b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t          v;
    logic [DW-1:0] same_exp;

    //            we_a  waddr_a wdata_a        we_b  waddr_b wdata_b        chk    exp_after
    vecs[0]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0000_0000, 5'd5,  32'hDEAD_BEEF};
    vecs[1]  = '{1'b1, 5'd7,  32'h1111_1111, 1'b1, 5'd7,  32'h2222_2222, 5'd7,  32'h2222_2222};
    vecs[2]  = '{1'b0, 5'd0,  32'h0000_0000, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  32'h0000_0000};
    vecs[3]  = '{1'b1, 5'd5,  32'h0000_CAFE, 1'b0, 5'd0,  32'h0000_0000, 5'd5,  32'h0000_CAFE};
    vecs[4]  = '{1'b1, 5'd9,  32'hA5A5_A5A5, 1'b1, 5'd10, 32'h5A5A_5A5A, 5'd10, 32'h5A5A_5A5A};
    vecs[5]  = '{1'b0, 5'd9,  32'h1234_5678, 1'b0, 5'd9,  32'h8765_4321, 5'd9,  32'hA5A5_A5A5};
    vecs[6]  = '{1'b1, 5'd0,  32'h0000_0001, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF};
    vecs[7]  = '{1'b1, 5'd0,  32'h0000_AAAA, 1'b1, 5'd0,  32'h0000_BBBB, 5'd0,  32'h0000_0000};
    vecs[8]  = '{1'b1, 5'd1,  32'h0000_0001, 1'b0, 5'd1,  32'hEEEE_EEEE, 5'd1,  32'h0000_0001};
    vecs[9]  = '{1'b1, 5'd5,  32'h0000_0044, 1'b1, 5'd5,  32'h0000_0055, 5'd5,  32'h0000_0055};
    vecs[10] = '{1'b1, 5'd9,  32'hC0FF_EE00, 1'b1, 5'd12, 32'h0000_0000, 5'd9,  32'hC0FF_EE00};

    for (int i = 0; i < NREG; i++) model[i] = '0;

    // Reset held two cycles; a write presented during reset must neither land nor forward.
    we_a = 1'b1; waddr_a = 5'd4; wdata_a = 32'h0000_0044;
    we_b = 1'b0; waddr_b = '0;   wdata_b = '0;
    dbg_re = 1'b0; dbg_raddr = '0;
    set_raddr(5'd4);
    @(posedge clk); #1;
    check_all("reset hold r4", '0);
    @(posedge clk); #1;
    check("reset dbg_rvalid", {31'b0, dbg_rvalid}, '0);
    check("reset dbg_rdata", dbg_rdata, '0);
    we_a = 1'b0;
    rstn = 1'b1;
    for (int a = 0; a < NREG; a++) begin
      set_raddr(AW'(a));
      #1;
      check_all($sformatf("post-reset r%0d", a), '0);
    end

    // Table-driven write/read/debug vectors.
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      we_a = v.we_a; waddr_a = v.waddr_a; wdata_a = v.wdata_a;
      we_b = v.we_b; waddr_b = v.waddr_b; wdata_b = v.wdata_b;
      set_raddr(v.chk_addr);
      dbg_re = 1'b1; dbg_raddr = v.chk_addr;
      #1;
`ifdef REGFILE_BYPASS_EN
      same_exp = v.exp_after;
`else
      same_exp = model[v.chk_addr];
`endif
      check($sformatf("v%0d same-cycle a1", i), rdata_a1, same_exp);
      check($sformatf("v%0d same-cycle b2", i), rdata_b2, same_exp);
      dbg_sb.push_back(v.exp_after);
      model_write(v);

      @(posedge clk); #1;
      // Disabled ports carry junk aimed at the checked register; it must have no effect.
      we_a = 1'b0; waddr_a = v.chk_addr; wdata_a = ~v.exp_after;
      we_b = 1'b0; waddr_b = v.chk_addr; wdata_b = 32'h0BAD_0BAD;
      dbg_re = 1'b0; dbg_raddr = v.chk_addr + 5'd1;
      check($sformatf("v%0d dbg_rvalid", i), {31'b0, dbg_rvalid}, 32'd1);
      if (dbg_rvalid) begin
        if (dbg_sb.size() == 0) check($sformatf("v%0d dbg scoreboard empty", i), dbg_rdata, ~dbg_rdata);
        else check($sformatf("v%0d dbg_rdata", i), dbg_rdata, dbg_sb.pop_front());
      end
      #1;
      check_all($sformatf("v%0d next-cycle", i), v.exp_after);

      @(posedge clk); #1;
      check($sformatf("v%0d dbg_rvalid drop", i), {31'b0, dbg_rvalid}, '0);
      check($sformatf("v%0d dbg_rdata hold", i), dbg_rdata, v.exp_after);
      check($sformatf("v%0d after junk", i), rdata_a1, v.exp_after);
    end
    check("dbg scoreboard drained", 32'(dbg_sb.size()), '0);

    // Async reset asserted mid-cycle while a write to r3 is pending.
    we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'h0000_0033;
    @(posedge clk); #1;
    wdata_a = 32'h0000_0077;
    set_raddr(5'd3);
    raddr_a2 = 5'd5;
    #1;
    check("pre-reset r3 stored", rdata_b1,
`ifdef REGFILE_BYPASS_EN
          32'h0000_0077);
`else
          32'h0000_0033);
`endif
    #2;
    rstn = 1'b0;
    #1;
    check("mid-reset r3 a1", rdata_a1, '0);
    check("mid-reset r5 a2", rdata_a2, '0);
    check("mid-reset dbg_rvalid", {31'b0, dbg_rvalid}, '0);
    @(posedge clk); #1;
    check("reset-edge r3", rdata_b2, '0);
    we_a = 1'b0;
    rstn = 1'b1;
    #1;
    check("post-release r3", rdata_a1, '0);
    check("post-release r5", rdata_a2, '0);
    for (int i = 0; i < NREG; i++) model[i] = '0;

    // First write after release lands at the next edge.
    we_b = 1'b1; waddr_b = 5'd3; wdata_b = 32'h0000_0099;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("first write same-cycle", rdata_a1, 32'h0000_0099);
`else
    check("first write same-cycle", rdata_a1, '0);
`endif
    @(posedge clk); #1;
    we_b = 1'b0;
    #1;
    check("first write landed", rdata_a1, 32'h0000_0099);
    check("first write r5 untouched", rdata_a2, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
